// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: frame state encoding,
// line levels and the parity helper.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam int   DATA_BITS  = 8;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A restart puts the count back to 0 so every frame begins on a bit boundary.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] baud_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (restart || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + W'(1);
    end
  end

  assign bit_end = (baud_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an asynchronous UART line: start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits, with back-to-back frames when data is waiting.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd,
  output logic             txd,
  output logic             tx_busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift_reg, shift_nx;
  logic       parity_bit, parity_nx;
  logic       txd_nx;
  logic       bit_end;
  logic       last_stop;
  logic       load_point;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(fifo_rd),
    .bit_end(bit_end)
  );

  // A new byte may be taken while idle or in the final cycle of the last stop bit,
  // which is what lets frames run with no gap between them.
  assign last_stop  = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  assign load_point = (state == IDLE) || last_stop;
  assign fifo_rd    = load_point & tx_en & ~fifo_empty & ~rst;
  assign tx_busy    = (state != IDLE);
  assign frame_done = last_stop;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift_reg;
    parity_nx  = parity_bit;
    txd_nx     = txd;

    if (fifo_rd) begin
      state_nx   = START;
      bit_cnt_nx = '0;
      shift_nx   = fifo_data;
      parity_nx  = parity_of(fifo_data, PARITY_ODD != 0);
      txd_nx     = LINE_START;
    end else if (bit_end) begin
      case (state)
        START: begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
          txd_nx     = shift_reg[0];
        end
        DATA: begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nx = '0;
            if (PARITY_EN != 0) begin
              state_nx = PARITY;
              txd_nx   = parity_bit;
            end else begin
              state_nx = STOP;
              txd_nx   = LINE_IDLE;
            end
          end else begin
            // txd is registered, so the next bit is shift_reg[1] before the shift lands.
            bit_cnt_nx = bit_cnt + 3'd1;
            shift_nx   = shift_reg >> 1;
            txd_nx     = shift_reg[1];
          end
        end
        PARITY: begin
          state_nx   = STOP;
          bit_cnt_nx = '0;
          txd_nx     = LINE_IDLE;
        end
        STOP: begin
          if (bit_cnt == LAST_STOP) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            txd_nx     = LINE_IDLE;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd        <= LINE_IDLE;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shift_reg  <= shift_nx;
      parity_bit <= parity_nx;
      txd        <= txd_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_sent <= '0;
    end else if (last_stop) begin
      frames_sent <= frames_sent + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Drives three transmitter variants (plain, odd parity + 2 stop, even parity) from
// a byte-FIFO model and checks every cycle against a frame-level reference.
module tb_fifo_uart_tx;

  localparam int CPB  = 4;
  localparam int NDUT = 3;

  function automatic int parEn(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int parOdd(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int stopBits(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int frameLen(input int i);
    return (1 + 8 + parEn(i) + stopBits(i)) * CPB;
  endfunction

  // Line level of bit slot n of a frame carrying byte b on variant i.
  function automatic logic frameBit(input logic [7:0] b, input int slot, input int i);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (parEn(i) != 0 && slot == 9) return (parOdd(i) != 0) ? ~^b : ^b;
    return 1'b1;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_en = 1'b0;
  logic [NDUT-1:0] fifo_empty;
  logic [NDUT-1:0] fifo_rd, txd, tx_busy, frame_done;
  logic [7:0]  fifo_data   [NDUT];
  logic [15:0] frames_sent [NDUT];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < NDUT; g++) begin : g_dut
    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (parEn(g)),
      .PARITY_ODD  (parOdd(g)),
      .STOP_BITS   (stopBits(g)),
      .CNT_W       (16)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty[g]),
      .fifo_data  (fifo_data[g]),
      .fifo_rd    (fifo_rd[g]),
      .txd        (txd[g]),
      .tx_busy    (tx_busy[g]),
      .frame_done (frame_done[g]),
      .frames_sent(frames_sent[g])
    );
  end

  logic [7:0]  fifoMem [NDUT][256];
  int          head [NDUT];
  int          tail [NDUT];
  logic        forceEmpty [NDUT];
  logic        mActive [NDUT];
  int          mCyc [NDUT];
  logic [7:0]  mByte [NDUT];
  logic [15:0] mCount [NDUT];
  int          numCompared;
  int          numMismatched;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic driveFifo();
    for (int i = 0; i < NDUT; i++) begin
      fifo_empty[i] = forceEmpty[i] || (head[i] == tail[i]);
      fifo_data[i]  = fifoMem[i][head[i]];
    end
  endtask

  task automatic pushByte(input int i, input logic [7:0] b);
    if (tail[i] < 255) begin
      fifoMem[i][tail[i]] = b;
      tail[i]++;
    end
    driveFifo();
  endtask

  task automatic modelReset();
    for (int i = 0; i < NDUT; i++) begin
      mActive[i] = 1'b0;
      mCyc[i]    = 0;
      mCount[i]  = '0;
    end
  endtask

  // One clock: compare at the falling edge, advance the models just after the rising edge.
  task automatic stepCycle();
    logic expRd [NDUT];
    logic actRd [NDUT];
    logic eTxd, eDone, eBusy;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      if (mActive[i]) begin
        eBusy = 1'b1;
        eTxd  = frameBit(mByte[i], mCyc[i] / CPB, i);
        eDone = (mCyc[i] == frameLen(i) - 1);
      end else begin
        eBusy = 1'b0;
        eTxd  = 1'b1;
        eDone = 1'b0;
      end
      expRd[i] = (!mActive[i] || eDone) && tx_en && !fifo_empty[i] && !rst;
      actRd[i] = fifo_rd[i];
      checkOutput($sformatf("fifo_rd%0d", i), 32'(fifo_rd[i]), 32'(expRd[i]));
      checkOutput($sformatf("txd%0d", i), 32'(txd[i]), 32'(eTxd));
      checkOutput($sformatf("tx_busy%0d", i), 32'(tx_busy[i]), 32'(eBusy));
      checkOutput($sformatf("frame_done%0d", i), 32'(frame_done[i]), 32'(eDone));
      checkOutput($sformatf("frames_sent%0d", i), 32'(frames_sent[i]), 32'(mCount[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        mActive[i] = 1'b0;
        mCyc[i]    = 0;
        mCount[i]  = '0;
      end else begin
        if (mActive[i]) begin
          if (mCyc[i] == frameLen(i) - 1) begin
            mActive[i] = 1'b0;
            mCount[i]  = mCount[i] + 16'd1;
          end else begin
            mCyc[i]++;
          end
        end
        if (expRd[i]) begin
          mActive[i] = 1'b1;
          mCyc[i]    = 0;
          mByte[i]   = fifoMem[i][head[i]];
        end
      end
      if (actRd[i] && head[i] < tail[i]) head[i]++;
    end
    driveFifo();
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) stepCycle();
  endtask

  task automatic checkCounts(input string tag, input int c0, input int c1, input int c2);
    checkOutput({tag, "_cnt0"}, 32'(frames_sent[0]), 32'(c0));
    checkOutput({tag, "_cnt1"}, 32'(frames_sent[1]), 32'(c1));
    checkOutput({tag, "_cnt2"}, 32'(frames_sent[2]), 32'(c2));
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    for (int i = 0; i < NDUT; i++) begin
      head[i] = 0;
      tail[i] = 0;
      forceEmpty[i] = 1'b0;
      for (int k = 0; k < 256; k++) fifoMem[i][k] = 8'h00;
    end
    modelReset();
    driveFifo();
    tx_en = 1'b1;
    #1 rst = 1'b1;

    // Reset, then idle with an empty FIFO.
    applyStimulus(3);
    rst = 1'b0;
    applyStimulus(20);
    checkCounts("idle", 0, 0, 0);

    // Single 8'hA5 frame on the plain variant.
    pushByte(0, 8'hA5);
    applyStimulus(45);
    checkCounts("a5", 1, 0, 0);

    // Back-to-back frames, plus 8'h07 on both parity variants.
    pushByte(0, 8'h00);
    pushByte(0, 8'hFF);
    pushByte(0, 8'h3C);
    pushByte(1, 8'h07);
    pushByte(2, 8'h07);
    applyStimulus(130);
    checkCounts("burst", 4, 1, 1);

    // Drop tx_en mid-frame with a second byte waiting.
    for (int i = 0; i < NDUT; i++) begin
      pushByte(i, 8'($urandom));
      pushByte(i, 8'($urandom));
    end
    applyStimulus(10);
    tx_en = 1'b0;
    applyStimulus(70);
    checkCounts("hold", 5, 2, 2);
    for (int i = 0; i < NDUT; i++)
      checkOutput($sformatf("held_depth%0d", i), 32'(tail[i] - head[i]), 32'd1);
    tx_en = 1'b1;
    applyStimulus(60);
    checkCounts("resume", 6, 3, 3);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < NDUT; i++) begin
      pushByte(i, 8'($urandom));
      pushByte(i, 8'($urandom));
    end
    applyStimulus(15);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("rst_txd%0d", i), 32'(txd[i]), 32'd1);
      checkOutput($sformatf("rst_busy%0d", i), 32'(tx_busy[i]), 32'd0);
    end
    modelReset();
    applyStimulus(3);
    rst = 1'b0;
    applyStimulus(60);
    checkCounts("after_rst", 1, 1, 1);

    // Random traffic, enable toggling, empty-flag glitches and occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) pushByte($urandom_range(0, NDUT - 1), 8'($urandom));
      if ($urandom_range(0, 49) == 0) tx_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NDUT; i++) forceEmpty[i] = ($urandom_range(0, 5) == 0);
      driveFifo();
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        #1;
        modelReset();
        stepCycle();
        rst = 1'b0;
      end else begin
        stepCycle();
      end
    end

    // Drain whatever is left.
    tx_en = 1'b1;
    for (int i = 0; i < NDUT; i++) forceEmpty[i] = 1'b0;
    driveFifo();
    applyStimulus(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
